// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader sits on the slave side; the byte source / memory model on the master side.
interface imem_loader_if #(
  parameter int ADDRESS_SIZE = 10,
  parameter int N            = 32
);
  logic                    byte_valid;
  logic [7:0]              byte_data;
  logic                    byte_ready;
  logic                    ins_write;
  logic [ADDRESS_SIZE-1:0] wr_addr;
  logic [N-1:0]            instruction_in;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, ins_write, wr_addr, instruction_in
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, ins_write, wr_addr, instruction_in
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: 16-bit word-count header, then little-endian
// 32-bit words written from address 0 upward; the core is held until the load completes.
module imem_byte_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= din;
  end
endmodule

module imem_loader #(
  parameter int ADDRESS_SIZE = 10,
  parameter int N            = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  imem_loader_if.slave      bus,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_error,
  output logic              cpu_run
);
  localparam int          NUM_LANES = N / 8;
  localparam logic [16:0] DEPTH     = 17'(2 ** ADDRESS_SIZE);

  typedef enum logic [2:0] {
    IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERROR
  } state_t;

  state_t                       state;
  logic [7:0]                   cnt_lo;
  logic [15:0]                  words_left;
  logic [1:0]                   idx;
  logic [ADDRESS_SIZE-1:0]      wr_addr_q;
  logic [N-1:0]                 instr_q;
  logic                         byte_ready_q;
  logic                         ins_write_q;
  logic                         xfer;
  logic [15:0]                  hdr_count;
  logic [NUM_LANES-2:0][7:0]    lane_q;

  assign xfer      = bus.byte_valid && byte_ready_q;
  assign hdr_count = {bus.byte_data, cnt_lo};

  // Lower byte lanes are staged here; the top byte goes straight into the word register.
  for (genvar g = 0; g < NUM_LANES - 1; g++) begin : g_lane
    imem_byte_lane u_lane (
      .clk (clk),
      .rst (rst),
      .en  (xfer && state == DATA && idx == 2'(g)),
      .din (bus.byte_data),
      .q   (lane_q[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt_lo       <= '0;
      words_left   <= '0;
      idx          <= '0;
      wr_addr_q    <= '0;
      instr_q      <= '0;
      byte_ready_q <= 1'b0;
      ins_write_q  <= 1'b0;
      load_busy    <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      cpu_run      <= 1'b0;
    end else begin
      ins_write_q <= 1'b0;
      case (state)
        IDLE: if (load_start) begin
          state        <= HDR_LO;
          byte_ready_q <= 1'b1;
          load_busy    <= 1'b1;
        end
        HDR_LO: if (xfer) begin
          cnt_lo <= bus.byte_data;
          state  <= HDR_HI;
        end
        HDR_HI: if (xfer) begin
          if (hdr_count == 16'd0) begin
            state        <= DONE;
            byte_ready_q <= 1'b0;
            load_busy    <= 1'b0;
            load_done    <= 1'b1;
            cpu_run      <= 1'b1;
          end else if ({1'b0, hdr_count} > DEPTH) begin
            state        <= ERROR;
            byte_ready_q <= 1'b0;
            load_busy    <= 1'b0;
            load_error   <= 1'b1;
          end else begin
            state      <= DATA;
            words_left <= hdr_count;
            wr_addr_q  <= '0;
            idx        <= '0;
          end
        end
        DATA: if (xfer) begin
          if (idx == 2'd3) begin
            instr_q      <= {bus.byte_data, lane_q};
            idx          <= '0;
            state        <= WRITE;
            byte_ready_q <= 1'b0;
            ins_write_q  <= 1'b1;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        WRITE: begin
          if (words_left == 16'd1) begin
            state     <= DONE;
            load_busy <= 1'b0;
            load_done <= 1'b1;
            cpu_run   <= 1'b1;
          end else begin
            state        <= DATA;
            words_left   <= words_left - 16'd1;
            wr_addr_q    <= wr_addr_q + 1'b1;
            idx          <= '0;
            byte_ready_q <= 1'b1;
          end
        end
        DONE: if (load_start) begin
          state        <= HDR_LO;
          load_done    <= 1'b0;
          cpu_run      <= 1'b0;
          load_busy    <= 1'b1;
          byte_ready_q <= 1'b1;
        end
        ERROR: if (load_start) begin
          state        <= HDR_LO;
          load_error   <= 1'b0;
          load_busy    <= 1'b1;
          byte_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready     = byte_ready_q;
  assign bus.ins_write      = ins_write_q;
  assign bus.wr_addr        = wr_addr_q;
  assign bus.instruction_in = instr_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header handling, word assembly, write timing,
// oversize/zero counts, byte_valid gaps and reset mid-load.
module tb_imem_loader;
  localparam int AS = 10;
  localparam int N  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_start = 1'b0;
  logic load_busy, load_done, load_error, cpu_run;
  logic [5:0] st;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int ready_in_write = 0;
  logic [AS-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

  imem_loader_if #(.ADDRESS_SIZE(AS), .N(N)) bus ();

  imem_loader #(.ADDRESS_SIZE(AS), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .bus        (bus.slave),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_error (load_error),
    .cpu_run    (cpu_run)
  );

  always #5 clk = ~clk;

  // {busy, done, error, cpu_run, byte_ready, ins_write}
  assign st = {load_busy, load_done, load_error, cpu_run, bus.byte_ready, bus.ins_write};

  always @(negedge clk) begin
    if (rst && bus.ins_write === 1'b1) begin
      wr_cnt++;
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.instruction_in);
      if (bus.byte_ready !== 1'b0) ready_in_write++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] max_word(input int i);
    return (i * 32'h01000193) ^ 32'hC0FFEE00;
  endfunction

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wr_cnt = 0;
    ready_in_write = 0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int waited);
    waited = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1", bus.byte_ready);
    end else begin
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    int wt;
    for (int i = 0; i < 4; i++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      send_byte(w[8*i +: 8], wt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (st !== 6'b000000) begin n_fail++; $display("FAIL reset_status: got %b required 000000", st); end
    n_checks++;
    if (bus.wr_addr !== '0 || bus.instruction_in !== '0) begin
      n_fail++; $display("FAIL reset_bus: wr_addr=%h instr=%h required 0/0", bus.wr_addr, bus.instruction_in);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (st !== 6'b000000) begin n_fail++; $display("FAIL idle_hold: got %b required 000000", st); end
  endtask

  task automatic test_two_word();
    int wt;
    logic [7:0] hdr_and_w0 [6] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00};
    logic [7:0] w1_rest [3] = '{8'h00, 8'hA0, 8'h00};
    clear_log();
    pulse_start();
    n_checks++;
    if (st !== 6'b100010) begin n_fail++; $display("FAIL two_hdr_lo: got %b required 100010", st); end
    foreach (hdr_and_w0[i]) send_byte(hdr_and_w0[i], wt);
    n_checks++;
    if (st !== 6'b100001) begin n_fail++; $display("FAIL two_write_cycle: got %b required 100001", st); end
    send_byte(8'hB3, wt);
    n_checks++;
    if (wt !== 1) begin n_fail++; $display("FAIL two_ready_latency: waited %0d required 1", wt); end
    foreach (w1_rest[i]) send_byte(w1_rest[i], wt);
    @(negedge clk);
    n_checks++;
    if (st !== 6'b010100) begin n_fail++; $display("FAIL two_done: got %b required 010100", st); end
    n_checks++;
    if (wr_cnt !== 2) begin n_fail++; $display("FAIL two_wr_cnt: got %0d required 2", wr_cnt); end
    n_checks++;
    if (wa_q.size() < 2 || wa_q[0] !== 10'd0 || wd_q[0] !== 32'h00500013 ||
        wa_q[1] !== 10'd1 || wd_q[1] !== 32'h00A000B3) begin
      n_fail++;
      $display("FAIL two_data: got %0d entries, first %h@%0d required 00500013@0 then 00A000B3@1",
               wa_q.size(), (wd_q.size() > 0) ? wd_q[0] : 32'hx, (wa_q.size() > 0) ? wa_q[0] : 10'hx);
    end
  endtask

  task automatic test_zero_count();
    int wt;
    clear_log();
    pulse_start();
    send_byte(8'h00, wt);
    send_byte(8'h00, wt);
    n_checks++;
    if (st !== 6'b010100) begin n_fail++; $display("FAIL zero_done: got %b required 010100", st); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_cnt !== 0) begin n_fail++; $display("FAIL zero_writes: got %0d required 0", wr_cnt); end
  endtask

  task automatic test_oversize();
    int wt;
    clear_log();
    pulse_start();
    send_byte(8'h01, wt);
    send_byte(8'h04, wt);
    n_checks++;
    if (st !== 6'b001000) begin n_fail++; $display("FAIL over_error: got %b required 001000", st); end
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    repeat (3) @(negedge clk);
    bus.byte_valid = 1'b0;
    n_checks++;
    if (st !== 6'b001000 || wr_cnt !== 0) begin
      n_fail++; $display("FAIL over_hold: got %b writes %0d required 001000 writes 0", st, wr_cnt);
    end
  endtask

  task automatic test_max_count();
    int wt;
    int bad;
    clear_log();
    pulse_start();
    n_checks++;
    if (st !== 6'b100010) begin n_fail++; $display("FAIL max_restart: got %b required 100010", st); end
    send_byte(8'h00, wt);
    send_byte(8'h04, wt);
    for (int i = 0; i < 1024; i++) send_word(max_word(i), 0);
    @(negedge clk);
    n_checks++;
    if (st !== 6'b010100) begin n_fail++; $display("FAIL max_done: got %b required 010100", st); end
    n_checks++;
    if (wr_cnt !== 1024) begin n_fail++; $display("FAIL max_wr_cnt: got %0d required 1024", wr_cnt); end
    bad = 0;
    for (int i = 0; i < wa_q.size() && i < 1024; i++)
      if (wa_q[i] !== 10'(i) || wd_q[i] !== max_word(i)) bad++;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL max_data: %0d wrong words required 0", bad); end
    n_checks++;
    if (wa_q.size() != 1024 || wa_q[1023] !== 10'd1023) begin
      n_fail++; $display("FAIL max_last_addr: got %0d entries required last at 1023", wa_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int wt;
    logic [31:0] w [3] = '{32'h00500013, 32'h00A000B3, 32'hDEADBEEF};
    int bad;
    clear_log();
    pulse_start();
    repeat ($urandom_range(0, 7)) @(negedge clk);
    send_byte(8'h03, wt);
    repeat ($urandom_range(0, 7)) @(negedge clk);
    send_byte(8'h00, wt);
    foreach (w[i]) send_word(w[i], 7);
    @(negedge clk);
    n_checks++;
    if (st !== 6'b010100) begin n_fail++; $display("FAIL gap_done: got %b required 010100", st); end
    n_checks++;
    if (wr_cnt !== 3) begin n_fail++; $display("FAIL gap_wr_cnt: got %0d required 3", wr_cnt); end
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (i >= wa_q.size() || wa_q[i] !== 10'(i) || wd_q[i] !== w[i]) bad++;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL gap_data: %0d wrong words required 0", bad); end
    n_checks++;
    if (ready_in_write !== 0) begin
      n_fail++; $display("FAIL gap_ready_in_write: got %0d cycles required 0", ready_in_write);
    end
  endtask

  task automatic test_reset_mid_load();
    int wt;
    clear_log();
    pulse_start();
    send_byte(8'h01, wt);
    send_byte(8'h00, wt);
    send_byte(8'h11, wt);
    send_byte(8'h22, wt);
    rst = 1'b0;
    #1;
    n_checks++;
    if (st !== 6'b000000 || bus.instruction_in !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: status %b instr %h required 000000 / 0", st, bus.instruction_in);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (st !== 6'b000000 || wr_cnt !== 0) begin
      n_fail++; $display("FAIL mid_idle: status %b writes %0d required 000000 / 0", st, wr_cnt);
    end
    pulse_start();
    send_byte(8'h01, wt);
    send_byte(8'h00, wt);
    send_word(32'h12345678, 0);
    @(negedge clk);
    n_checks++;
    if (st !== 6'b010100) begin n_fail++; $display("FAIL mid_reload_done: got %b required 010100", st); end
    n_checks++;
    if (wr_cnt !== 1 || wa_q.size() != 1 || wa_q[0] !== 10'd0 || wd_q[0] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL mid_reload_data: writes %0d first %h required 1 write 12345678@0",
               wr_cnt, (wd_q.size() > 0) ? wd_q[0] : 32'hx);
    end
    pulse_start();
    n_checks++;
    if (st !== 6'b100010) begin n_fail++; $display("FAIL done_restart: got %b required 100010", st); end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_zero_count();
    test_oversize();
    test_max_count();
    test_back_to_back();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader and sequencer for the processor's instruction memory.
- Accepts a byte stream (UART/debug-port side) over a valid/ready handshake: a 16-bit word-count header, then that many little-endian 32-bit instructions.
- Drives the memory's write port (ins_write, wr_addr, instruction_in) from address 0 upward.
- Holds the core stopped (cpu_run=0) until the load completes.

Parameters:
- ADDRESS_SIZE, 10, instruction-memory word-address width; depth = 2**ADDRESS_SIZE words
- N, 32, instruction width; fixed at 32, since words are assembled from 4 bytes

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- load_start  input  1  single-cycle pulse; begins a load sequence
- byte_valid  input  1  byte_data holds a valid byte
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts byte_data this cycle
- ins_write  output  1  memory write strobe, one cycle per word
- wr_addr  output  ADDRESS_SIZE  memory word address
- instruction_in  output  N  assembled instruction word
- load_busy  output  1  load sequence in progress
- load_done  output  1  last load completed successfully
- load_error  output  1  last load aborted (count too large)
- cpu_run  output  1  core may fetch/execute

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - All outputs 0.
  - Internal word counter, byte index and assembly register cleared.
- Byte acceptance: a byte transfers on a rising edge where byte_valid=1 and byte_ready=1.
  - byte_ready=1 only in HDR_LO, HDR_HI and DATA; 0 in every other state.
- States:
  - IDLE: on load_start -> HDR_LO.
  - HDR_LO: on a transfer, count[7:0] = byte -> HDR_HI.
  - HDR_HI: on a transfer, count[15:8] = byte, then:
    - full count == 0 -> DONE
    - full count > 2**ADDRESS_SIZE -> ERROR
    - otherwise -> DATA with wr_addr = 0 and byte index = 0.
  - DATA: each transfer stores the byte into lane [8*idx+7:8*idx] (idx 0..3, little-endian).
    - On the transfer with idx = 3, register the full word onto instruction_in -> WRITE.
  - WRITE: exactly one cycle.
    - ins_write=1 with a stable wr_addr and instruction_in; the memory captures them on this cycle's closing edge.
    - Next state: DONE if this was the last word; otherwise increment wr_addr, clear idx -> DATA.
  - DONE: load_done=1, cpu_run=1. On load_start -> HDR_LO and clear load_done and cpu_run.
  - ERROR: load_error=1, cpu_run=0; no further bytes accepted. On load_start -> HDR_LO and clear load_error.
- load_busy = 1 in HDR_LO, HDR_HI, DATA and WRITE.
- load_start is ignored in HDR_LO, HDR_HI, DATA and WRITE.
- Word-count arithmetic:
  - Count is compared as 17-bit, so 2**ADDRESS_SIZE is legal and 2**ADDRESS_SIZE+1 is an error.
  - The internal remaining-words counter is 16 bits; wr_addr never wraps within a legal load.
- Latency: the 4th byte of a word is accepted at edge k; ins_write=1 during cycle k+1; byte_ready returns at cycle k+2.
  - Minimum throughput is 5 cycles per word with byte_valid held high.
- byte_valid gaps: any number of idle cycles between bytes; state and partial word are held.
- ins_write is never asserted outside WRITE.
- instruction_in and wr_addr hold their last values when not writing. Verification checks them only while ins_write=1.
- Reset mid-load: immediate return to IDLE with cpu_run=0. The partial word is discarded; no ins_write is produced.
- The memory's read port returns 0 while ins_write=1. This is harmless because cpu_run=0 throughout any load.

Test Plan:
- Reset values: hold rst=0 for 3 cycles, release -> all outputs 0, byte_ready=0; no load_start for 10 cycles -> still IDLE.
- Two-word load: load_start, then bytes 02 00 13 00 50 00 B3 00 A0 00, byte_valid continuous.
  - Expect ins_write at addr 0 with 0x00500013, then at addr 1 with 0x00A000B3.
  - Then load_done=1, cpu_run=1; 2 write strobes total.
- Zero count: header 00 00 -> DONE on the cycle after the HDR_HI transfer; no ins_write; cpu_run=1.
- Oversize count with ADDRESS_SIZE=10:
  - Header 01 04 (1025) -> load_error=1, byte_ready=0, cpu_run=0, no writes.
  - Header 00 04 (1024) with 4096 data bytes -> last write at wr_addr=1023, then load_done=1.
- Back-pressure and gaps: random byte_valid gaps of 0-7 cycles during a 3-word load -> same addresses and data as the gap-free run; exactly 3 ins_write pulses; no byte accepted while in WRITE.
- Reset mid-load and restart:
  - Assert rst after the 2nd data byte of word 1 -> immediate IDLE, no write.
  - Then perform a full 1-word load; then pulse load_start in DONE -> cpu_run drops next cycle and the loader re-enters HDR_LO.
